// File: rtl/pingpong_pkg.sv
// Shared types and helpers for the ping-pong block buffer.
package pingpong_pkg;

  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } bank_state_t;

  localparam int NBANKS = 2;

  function automatic logic next_bank(input logic b);
    return ~b;
  endfunction

endpackage

// File: rtl/blockbuf_bank.sv
// One storage bank: synchronous write port, registered random-read port.
// Reads beyond the last word return zero so a non-power-of-two LEN never
// exposes a nonexistent location.
module blockbuf_bank
  import pingpong_pkg::*;
#(
  parameter int LEN = 8,
  parameter int WID = 8,
  localparam int AW = $clog2(LEN)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [WID-1:0] wr_data,
  input  logic [AW-1:0]  rd_addr,
  output logic [WID-1:0] rd_data
);

  localparam logic [AW:0] LEN_W = (AW+1)'(LEN);

  logic [WID-1:0] mem [LEN];
  logic [WID-1:0] rd_data_d;
  logic [WID-1:0] rd_data_q;

  // Storage is never cleared; only the write port touches it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Range-checked read lookup.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < LEN_W) rd_data_d = mem[rd_addr];
  end

  // Read register, cleared by reset and by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data_q <= '0;
    else if (flush) rd_data_q <= '0;
    else            rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pingpong_blockbuf.sv
// Double-buffered block buffer: the writer fills one bank sequentially while
// the consumer randomly reads the other, completed bank and frees it with an
// explicit release pulse.
module pingpong_blockbuf
  import pingpong_pkg::*;
#(
  parameter int LEN = 8,
  parameter int WID = 8,
  localparam int AW = $clog2(LEN)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           wr_valid,
  input  logic [WID-1:0] wr_data,
  output logic           wr_ready,
  output logic [AW:0]    wr_count,
  output logic           rd_valid,
  output logic           rd_bank,
  input  logic [AW-1:0]  rd_addr,
  output logic [WID-1:0] rd_data,
  input  logic           rd_release,
  output logic           overflow
);

  localparam logic [AW:0] LAST = (AW+1)'(LEN - 1);

  logic        wbank_q, wbank_d;
  logic        rbank_q, rbank_d;
  logic        rd_sel_q, rd_sel_d;
  logic        overflow_q, overflow_d;
  logic [AW:0] wr_count_q, wr_count_d;
  bank_state_t state_q [NBANKS];
  bank_state_t state_d [NBANKS];

  logic           wr_fire;
  logic           rel_fire;
  logic [WID-1:0] bank_rd [NBANKS];

  assign wr_ready = (state_q[wbank_q] == FREE);
  assign rd_valid = (state_q[rbank_q] == FULL);
  assign wr_fire  = wr_valid & wr_ready;
  assign rel_fire = rd_release & rd_valid;

  // Next-state for pointers, bank states, fill count and the overflow flag.
  // A completing write and a release can coincide; they always hit different
  // banks, so both updates are applied independently.
  always_comb begin
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    state_d    = state_q;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;
    rd_sel_d   = rbank_q;
    if (flush) begin
      wbank_d    = 1'b0;
      rbank_d    = 1'b0;
      state_d[0] = FREE;
      state_d[1] = FREE;
      wr_count_d = '0;
      overflow_d = 1'b0;
      rd_sel_d   = 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_count_q == LAST) begin
          state_d[wbank_q] = FULL;
          wr_count_d       = '0;
          wbank_d          = next_bank(wbank_q);
        end else begin
          wr_count_d = wr_count_q + (AW+1)'(1);
        end
      end
      if (rel_fire) begin
        state_d[rbank_q] = FREE;
        rbank_d          = next_bank(rbank_q);
      end
      if (wr_valid && !wr_ready) overflow_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      rd_sel_q   <= 1'b0;
      overflow_q <= 1'b0;
      wr_count_q <= '0;
      state_q[0] <= FREE;
      state_q[1] <= FREE;
    end else begin
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      rd_sel_q   <= rd_sel_d;
      overflow_q <= overflow_d;
      wr_count_q <= wr_count_d;
      state_q    <= state_d;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    blockbuf_bank #(
      .LEN(LEN),
      .WID(WID)
    ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .wr_en  (wr_fire & ~flush & (wbank_q == 1'(b))),
      .wr_addr(wr_count_q[AW-1:0]),
      .wr_data(wr_data),
      .rd_addr(rd_addr),
      .rd_data(bank_rd[b])
    );
  end

  // rd_sel_q remembers which bank was readable when the read was sampled.
  assign rd_data  = rd_sel_q ? bank_rd[1] : bank_rd[0];
  assign rd_bank  = rbank_q;
  assign wr_count = wr_count_q;
  assign overflow = overflow_q;

endmodule
